// File: rtl/mbist_pkg.sv
// Shared types and constant March element tables for the MBIST controller.
package mbist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic ALG_MATSP  = 1'b0;
  localparam logic ALG_MARCHC = 1'b1;

  localparam int ELEM_W = 3;
  typedef logic [ELEM_W-1:0] elem_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // One March element: address direction, one or two ops per address,
  // and the op type / data background (all-0 or all-1) of each op.
  typedef struct packed {
    logic down;
    logic two_ops;
    op_t  op0;
    logic bg0;
    op_t  op1;
    logic bg1;
  } elem_desc_t;

  localparam elem_t MATSP_ELEMS  = 3'd3;
  localparam elem_t MARCHC_ELEMS = 3'd6;

  function automatic elem_t elem_count(input logic alg);
    return (alg == ALG_MARCHC) ? MARCHC_ELEMS : MATSP_ELEMS;
  endfunction

  // Direction alone, so the address generator can be preloaded for the
  // next element without decoding the whole descriptor.
  function automatic logic elem_down(input logic alg, input elem_t elem);
    if (alg == ALG_MARCHC) begin
      return (elem == 3'd3) || (elem == 3'd4);
    end
    return (elem == 3'd2);
  endfunction

  function automatic elem_desc_t elem_desc(input logic alg, input elem_t elem);
    elem_desc_t d;
    d.down    = elem_down(alg, elem);
    d.two_ops = 1'b1;
    d.op0     = OP_READ;
    d.bg0     = 1'b0;
    d.op1     = OP_WRITE;
    d.bg1     = 1'b1;
    if (alg == ALG_MARCHC) begin
      case (elem)
        3'd0: begin d.two_ops = 1'b0; d.op0 = OP_WRITE; d.bg0 = 1'b0; d.bg1 = 1'b0; end
        3'd1: begin d.bg0 = 1'b0; d.bg1 = 1'b1; end
        3'd2: begin d.bg0 = 1'b1; d.bg1 = 1'b0; end
        3'd3: begin d.bg0 = 1'b0; d.bg1 = 1'b1; end
        3'd4: begin d.bg0 = 1'b1; d.bg1 = 1'b0; end
        default: begin d.two_ops = 1'b0; d.op0 = OP_READ; d.bg0 = 1'b0; d.bg1 = 1'b0; end
      endcase
    end else begin
      case (elem)
        3'd0: begin d.two_ops = 1'b0; d.op0 = OP_WRITE; d.bg0 = 1'b0; d.bg1 = 1'b0; end
        3'd1: begin d.bg0 = 1'b0; d.bg1 = 1'b1; end
        default: begin d.bg0 = 1'b1; d.bg1 = 1'b0; end
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Single-port synchronous SRAM bus between the BIST controller and the memory.
interface mbist_march_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic              re;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output addr, output we, output re, output wdata, input rdata);
  modport slave  (input addr, input we, input re, input wdata, output rdata);
endinterface

// File: rtl/mbist_addr_gen.sv
// Up/down address counter with direction-dependent preload and end flag.
module mbist_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_down,
  input  logic              en,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  logic [ADDR_W-1:0] addr_reg;

  // Preload to the first address of an element, otherwise step when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg <= '0;
    end else if (load) begin
      addr_reg <= load_down ? ADDR_MAX : '0;
    end else if (en) begin
      addr_reg <= down ? (addr_reg - 1'b1) : (addr_reg + 1'b1);
    end
  end

  assign addr = addr_reg;
  assign last = down ? (addr_reg == '0) : (addr_reg == ADDR_MAX);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March-test BIST controller: MATS+ / March C- sequencing, registered SRAM
// drive, two-stage read-compare pipeline and first-fail capture.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               alg,
  input  logic               stop_on_fail,
  mbist_march_ctrl_if.master mem,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [ADDR_W-1:0]  fail_addr,
  output logic [2:0]         fail_elem,
  output logic [DATA_W-1:0]  fail_exp,
  output logic [DATA_W-1:0]  fail_act
);

  state_t            state_reg, state_next;
  logic              alg_reg, stop_reg, phase_reg, last_issued_reg;
  elem_t             elem_reg;

  logic [ADDR_W-1:0] addr;
  logic              addr_last;
  logic              ag_load, ag_load_down, ag_en;

  elem_desc_t        cur_desc;
  logic              cur_is_wr, cur_bg, last_elem;
  logic              start_ok, issue, mismatch, stop_abort;

  logic [ADDR_W-1:0] mem_addr_reg;
  logic              mem_we_reg, mem_re_reg;
  logic [DATA_W-1:0] mem_wdata_reg;

  // Read tracking: stage rd_* travels with mem_re, stage chk_* lines up
  // with mem_rdata one cycle later.
  logic              rd_valid_reg, chk_valid_reg;
  logic [ADDR_W-1:0] rd_addr_reg, chk_addr_reg;
  logic [DATA_W-1:0] rd_exp_reg, chk_exp_reg;
  elem_t             rd_elem_reg, chk_elem_reg;

  logic              fail_reg;
  logic [ADDR_W-1:0] fail_addr_reg;
  elem_t             fail_elem_reg;
  logic [DATA_W-1:0] fail_exp_reg, fail_act_reg;

  mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (ag_load),
    .load_down (ag_load_down),
    .en        (ag_en),
    .down      (cur_desc.down),
    .addr      (addr),
    .last      (addr_last)
  );

  // Current-op decode, compare result and address generator control.
  always_comb begin
    cur_desc     = elem_desc(alg_reg, elem_reg);
    cur_is_wr    = phase_reg ? (cur_desc.op1 == OP_WRITE) : (cur_desc.op0 == OP_WRITE);
    cur_bg       = phase_reg ? cur_desc.bg1 : cur_desc.bg0;
    last_elem    = (elem_reg == (elem_count(alg_reg) - 3'd1));
    start_ok     = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    mismatch     = chk_valid_reg && (mem.rdata != chk_exp_reg);
    stop_abort   = mismatch && stop_reg && (state_reg == ST_RUN);
    issue        = (state_reg == ST_RUN) && !last_issued_reg && !stop_abort;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_en        = 1'b0;
    if (start_ok) begin
      ag_load      = 1'b1;
      ag_load_down = elem_down(alg, 3'd0);
    end else if (issue && (!cur_desc.two_ops || phase_reg)) begin
      if (!addr_last) begin
        ag_en = 1'b1;
      end else if (!last_elem) begin
        ag_load      = 1'b1;
        ag_load_down = elem_down(alg_reg, elem_reg + 3'd1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        if (stop_abort)           state_next = ST_DONE;
        else if (last_issued_reg) state_next = ST_FLUSH;
      end
      default:                    state_next = ST_DONE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Element / op-phase sequencing and per-run configuration latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alg_reg         <= ALG_MATSP;
      stop_reg        <= 1'b0;
      elem_reg        <= '0;
      phase_reg       <= 1'b0;
      last_issued_reg <= 1'b0;
    end else if (start_ok) begin
      alg_reg         <= alg;
      stop_reg        <= stop_on_fail;
      elem_reg        <= '0;
      phase_reg       <= 1'b0;
      last_issued_reg <= 1'b0;
    end else if (issue) begin
      if (cur_desc.two_ops && !phase_reg) begin
        phase_reg <= 1'b1;
      end else begin
        phase_reg <= 1'b0;
        if (addr_last) begin
          if (last_elem) last_issued_reg <= 1'b1;
          else           elem_reg        <= elem_reg + 3'd1;
        end
      end
    end
  end

  // Registered memory drive; strobes are low whenever no op is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_reg  <= '0;
      mem_we_reg    <= 1'b0;
      mem_re_reg    <= 1'b0;
      mem_wdata_reg <= '0;
    end else begin
      mem_addr_reg  <= issue ? addr : '0;
      mem_we_reg    <= issue && cur_is_wr;
      mem_re_reg    <= issue && !cur_is_wr;
      mem_wdata_reg <= (issue && cur_is_wr) ? {DATA_W{cur_bg}} : '0;
    end
  end

  // Read-compare pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_reg  <= 1'b0;
      rd_addr_reg   <= '0;
      rd_exp_reg    <= '0;
      rd_elem_reg   <= '0;
      chk_valid_reg <= 1'b0;
      chk_addr_reg  <= '0;
      chk_exp_reg   <= '0;
      chk_elem_reg  <= '0;
    end else begin
      rd_valid_reg  <= issue && !cur_is_wr && !start_ok;
      rd_addr_reg   <= addr;
      rd_exp_reg    <= {DATA_W{cur_bg}};
      rd_elem_reg   <= elem_reg;
      chk_valid_reg <= rd_valid_reg && !start_ok;
      chk_addr_reg  <= rd_addr_reg;
      chk_exp_reg   <= rd_exp_reg;
      chk_elem_reg  <= rd_elem_reg;
    end
  end

  // Sticky fail flag; diagnostics hold the first mismatch of the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_reg      <= 1'b0;
      fail_addr_reg <= '0;
      fail_elem_reg <= '0;
      fail_exp_reg  <= '0;
      fail_act_reg  <= '0;
    end else if (start_ok) begin
      fail_reg      <= 1'b0;
      fail_addr_reg <= '0;
      fail_elem_reg <= '0;
      fail_exp_reg  <= '0;
      fail_act_reg  <= '0;
    end else if (mismatch) begin
      fail_reg <= 1'b1;
      if (!fail_reg) begin
        fail_addr_reg <= chk_addr_reg;
        fail_elem_reg <= chk_elem_reg;
        fail_exp_reg  <= chk_exp_reg;
        fail_act_reg  <= mem.rdata;
      end
    end
  end

  assign mem.addr  = mem_addr_reg;
  assign mem.we    = mem_we_reg;
  assign mem.re    = mem_re_reg;
  assign mem.wdata = mem_wdata_reg;

  assign busy      = (state_reg == ST_RUN) || (state_reg == ST_FLUSH);
  assign done      = (state_reg == ST_DONE);
  assign fail      = fail_reg;
  assign fail_addr = fail_addr_reg;
  assign fail_elem = fail_elem_reg;
  assign fail_exp  = fail_exp_reg;
  assign fail_act  = fail_act_reg;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Testbench for mbist_march_ctrl: SRAM with optional stuck-at fault, an
// op-list reference model built from the March tables, and a per-cycle
// compare of every DUT output against that model.
`timescale 1ns/1ps
module tb_mbist_march_ctrl;
  localparam int AW = 2;
  localparam int DW = 4;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic alg = 1'b0;
  logic stop_on_fail = 1'b0;
  logic busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_exp, fail_act;

  int checks = 0;
  int errors = 0;

  mbist_march_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .alg          (alg),
    .stop_on_fail (stop_on_fail),
    .mem          (mem_if),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .fail_addr    (fail_addr),
    .fail_elem    (fail_elem),
    .fail_exp     (fail_exp),
    .fail_act     (fail_act)
  );

  always #5 clk = ~clk;

  // ---------------- memory under test with one optional stuck-at cell
  logic          fault_en = 1'b0;
  int            fault_addr = 0;
  logic [DW-1:0] fault_mask = '0;
  logic          fault_sa1 = 1'b0;
  logic [DW-1:0] sram [N];

  function automatic logic [DW-1:0] faulty(int a, logic [DW-1:0] d);
    if (fault_en && a == fault_addr)
      return fault_sa1 ? (d | fault_mask) : (d & ~fault_mask);
    return d;
  endfunction

  always @(posedge clk) begin
    if (mem_if.we) sram[mem_if.addr] <= faulty(int'(mem_if.addr), mem_if.wdata);
    if (mem_if.re) mem_if.rdata <= sram[mem_if.addr];
  end

  // ---------------- reference model
  typedef struct {
    bit            we;
    bit            re;
    int            addr;
    logic [DW-1:0] wdata;
    int            elem;
    logic [DW-1:0] expd;
  } op_s;

  op_s           ops[$];
  int            m_T, m_nbus, m_f, m_faddr, m_felem;
  bit            m_fvalid;
  logic [DW-1:0] m_fexp, m_fact;
  bit            m_active = 0;
  int            m_cyc = 0;

  // Expand one March element, written as text such as "r0w1".
  function automatic void add_elem(int e, bit down, string seq);
    int  a;
    byte c;
    byte v;
    op_s o;
    for (int j = 0; j < N; j++) begin
      a = down ? (N - 1 - j) : j;
      for (int p = 0; p < seq.len(); p += 2) begin
        c = seq[p];
        v = seq[p+1];
        o.we    = (c == "w");
        o.re    = (c == "r");
        o.addr  = a;
        o.elem  = e;
        o.expd  = {DW{v == "1"}};
        o.wdata = o.we ? o.expd : '0;
        ops.push_back(o);
      end
    end
  endfunction

  function automatic void build_model(bit a, bit s);
    logic [DW-1:0] mm [N];
    ops.delete();
    if (!a) begin
      add_elem(0, 0, "w0"); add_elem(1, 0, "r0w1"); add_elem(2, 1, "r1w0");
    end else begin
      add_elem(0, 0, "w0");   add_elem(1, 0, "r0w1"); add_elem(2, 0, "r1w0");
      add_elem(3, 1, "r0w1"); add_elem(4, 1, "r1w0"); add_elem(5, 0, "r0");
    end
    m_fvalid = 0; m_f = 0; m_faddr = 0; m_felem = 0; m_fexp = '0; m_fact = '0;
    foreach (ops[i]) begin
      if (ops[i].we) mm[ops[i].addr] = faulty(ops[i].addr, ops[i].wdata);
      if (ops[i].re && !m_fvalid && mm[ops[i].addr] !== ops[i].expd) begin
        m_fvalid = 1; m_f = i; m_faddr = ops[i].addr; m_felem = ops[i].elem;
        m_fexp = ops[i].expd; m_fact = mm[ops[i].addr];
      end
    end
    // Ops appear on the bus one cycle after start; a read's verdict lands
    // two cycles after it appears, and an abort ends the run at that edge.
    if (s && m_fvalid) begin
      m_T    = m_f + 3;
      m_nbus = (m_f + 2 < ops.size()) ? (m_f + 2) : ops.size();
    end else begin
      m_T    = ops.size() + 2;
      m_nbus = ops.size();
    end
  endfunction

  // Model timeline: cycle count since the accepted start edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0;
      m_cyc    = 0;
    end else if (start && (!m_active || m_cyc >= m_T)) begin
      build_model(alg, stop_on_fail);
      m_active = 1;
      m_cyc    = 0;
    end else if (m_active) begin
      m_cyc++;
    end
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t cyc=%0d: got %0h expected %0h", name, $time, m_cyc, got, want);
    end
  endtask

  // ---------------- per-cycle compare
  logic          c_we, c_re, c_busy, c_done, c_fail;
  int            c_addr, c_felem;
  logic [DW-1:0] c_wd, c_fexp, c_fact;
  int            c_faddr;

  always @(negedge clk) begin
    if (!rst) begin
      c_we = 0; c_re = 0; c_addr = 0; c_wd = '0;
      c_busy = 0; c_done = 0; c_fail = 0;
      c_faddr = 0; c_felem = 0; c_fexp = '0; c_fact = '0;
      if (m_active) begin
        if (m_cyc >= 1 && m_cyc - 1 < m_nbus) begin
          c_we   = ops[m_cyc-1].we;
          c_re   = ops[m_cyc-1].re;
          c_addr = ops[m_cyc-1].addr;
          c_wd   = ops[m_cyc-1].wdata;
        end
        c_busy = (m_cyc < m_T);
        c_done = (m_cyc >= m_T);
        if (m_fvalid && m_cyc >= m_f + 3) begin
          c_fail = 1; c_faddr = m_faddr; c_felem = m_felem; c_fexp = m_fexp; c_fact = m_fact;
        end
      end
      check("mem_we",    32'(mem_if.we),    32'(c_we));
      check("mem_re",    32'(mem_if.re),    32'(c_re));
      check("we_re_excl", 32'(mem_if.we & mem_if.re), 32'd0);
      check("mem_addr",  32'(mem_if.addr),  32'(c_addr));
      check("mem_wdata", 32'(mem_if.wdata), 32'(c_wd));
      check("busy",      32'(busy),         32'(c_busy));
      check("done",      32'(done),         32'(c_done));
      check("fail",      32'(fail),         32'(c_fail));
      check("fail_addr", 32'(fail_addr),    32'(c_faddr));
      check("fail_elem", 32'(fail_elem),    32'(c_felem));
      check("fail_exp",  32'(fail_exp),     32'(c_fexp));
      check("fail_act",  32'(fail_act),     32'(c_fact));
    end
  end

  // ---------------- stimulus
  task automatic set_fault(bit en, int a, int b, bit sa1);
    fault_en   = en;
    fault_addr = a;
    fault_mask = DW'(1) << b;
    fault_sa1  = sa1;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_we"},   32'(mem_if.we),   32'd0);
    check({tag, "_re"},   32'(mem_if.re),   32'd0);
    check({tag, "_busy"}, 32'(busy),        32'd0);
    check({tag, "_done"}, 32'(done),        32'd0);
    check({tag, "_fail"}, 32'(fail),        32'd0);
    check({tag, "_faddr"}, 32'(fail_addr),  32'd0);
    check({tag, "_fact"}, 32'(fail_act),    32'd0);
  endtask

  // One run: start pulse, then T+2 cycles with optional ignored start
  // pulses and alg/stop toggling while the run is in progress.
  task automatic run(bit a, bit s, bit noisy);
    int t;
    @(negedge clk);
    start = 1'b1; alg = a; stop_on_fail = s;
    @(negedge clk);
    start = 1'b0;
    t = m_T;
    for (int c = 1; c <= t + 2; c++) begin
      if (noisy && c < t) begin
        start = ($urandom_range(0, 5) == 0);
        alg = 1'($urandom);
        stop_on_fail = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    $display("run alg=%0d stop=%0d fault=%0d@%0d mask=%0h sa1=%0d noisy=%0d done_cycle=%0d fail=%0d",
             a, s, fault_en, fault_addr, fault_mask, fault_sa1, noisy, t, m_fvalid);
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Clean MATS+.
    set_fault(0, 0, 0, 0);
    run(1'b0, 1'b0, 1'b0);
    check("pin_matsp_T", 32'(m_T), 32'd22);
    check("pin_op0", {30'd0, ops[0].we, ops[0].re}, 32'd2);
    check("pin_op12_addr", 32'(ops[12].addr), 32'd3);
    check("pin_op12_exp", 32'(ops[12].expd), 32'hF);
    check("matsp_done", 32'(done), 32'd1);
    check("matsp_fail", 32'(fail), 32'd0);

    // Clean March C-.
    run(1'b1, 1'b0, 1'b0);
    check("pin_marchc_T", 32'(m_T), 32'd42);
    check("pin_marchc_ops", 32'(ops.size()), 32'd40);
    check("marchc_done", 32'(done), 32'd1);

    // Stuck-at-1 on bit0 of address 2, run to completion.
    set_fault(1, 2, 0, 1);
    run(1'b0, 1'b0, 1'b0);
    check("pin_f_addr", 32'(m_faddr), 32'd2);
    check("pin_f_elem", 32'(m_felem), 32'd1);
    check("pin_f_exp",  32'(m_fexp),  32'h0);
    check("pin_f_act",  32'(m_fact),  32'h1);
    check("sa1_fail_addr", 32'(fail_addr), 32'd2);
    check("sa1_fail_elem", 32'(fail_elem), 32'd1);
    check("sa1_fail_act",  32'(fail_act),  32'h1);

    // Same fault, abort on first mismatch.
    run(1'b0, 1'b1, 1'b0);
    check("pin_stop_T", 32'(m_T), 32'd11);
    check("stop_done", 32'(done), 32'd1);

    // Asynchronous reset in the middle of a March C- run.
    set_fault(0, 0, 0, 0);
    @(negedge clk);
    start = 1'b1; alg = 1'b1; stop_on_fail = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    run(1'b0, 1'b0, 1'b0);

    // Ignored start pulses and alg toggles during a run.
    run(1'b1, 1'b0, 1'b1);

    // Randomised runs.
    for (int i = 0; i < 24; i++) begin
      set_fault($urandom_range(0, 1), $urandom_range(0, N - 1),
                $urandom_range(0, DW - 1), $urandom_range(0, 1));
      run(1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
